// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types, defaults and helpers for the SAR ADC controller
// Contents:
//   SAR_*_DEF       default parameter values for sar_adc_ctrl
//   sar_state_e     controller state encoding
//   sar_cnt_width() width of a down-counter that holds 0..max_val-1
package sar_pkg;

    localparam int SAR_NBITS_DEF         = 8;
    localparam int SAR_SAMPLE_CYCLES_DEF = 4;
    localparam int SAR_SETTLE_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_TRIAL  = 3'd2,
        ST_DONE   = 3'd3,
        ST_SHIFT  = 3'd4
    } sar_state_e;

    // Never narrower than one bit, even when the counter only ever holds 0.
    function automatic int sar_cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/sar_ser_tx.sv
// rtl/sar_ser_tx.sv - MSB-first serialiser for a completed conversion result
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        one-cycle strobe; captures load_data and starts shifting next cycle
//   load_data   NBITS word to transmit
//   ser_data    current serial bit (0 when not valid)
//   ser_valid   ser_data qualifier, high for NBITS cycles after load
//   tx_busy     a word is being shifted out
module sar_ser_tx
    import sar_pkg::*;
#(
    parameter int NBITS = SAR_NBITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [NBITS-1:0] load_data,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             tx_busy
);

    localparam int CW = sar_cnt_width(NBITS + 1);

    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    left_q,  left_d;
    logic             valid_q, valid_d;

    always_comb begin
        shreg_d = shreg_q;
        left_d  = left_q;
        valid_d = 1'b0;
        if (load) begin
            shreg_d = load_data;
            left_d  = CW'(NBITS);
            valid_d = 1'b1;
        end else if (left_q != '0) begin
            shreg_d = shreg_q << 1;
            left_d  = left_q - CW'(1);
            // Valid stays up while at least one more bit follows the current one.
            valid_d = (left_q > CW'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            left_q  <= left_d;
            valid_q <= valid_d;
        end
    end

    assign ser_data  = shreg_q[NBITS-1] & valid_q;
    assign ser_valid = valid_q;
    assign tx_busy   = valid_q;

endmodule

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation controller for the LPCAS analog macro
// Optional feature macro: SAR_SERIAL_OUT_EN (adds the SHIFT state and serial output).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         single-cycle conversion request (ignored while busy or in DONE)
//   cmp_in        comparator decision, 1 = Vin >= Vdac, already synchronised
//   sample_en     track/hold switch enable
//   dac_code      trial code to the capacitive DAC
//   busy          conversion or serial shift in progress
//   result        last completed conversion
//   result_valid  one-cycle pulse when result updates
//   ser_data      serial result bit, MSB first (0 without SAR_SERIAL_OUT_EN)
//   ser_valid     ser_data qualifier (0 without SAR_SERIAL_OUT_EN)
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int NBITS         = SAR_NBITS_DEF,
    parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SAR_SETTLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample_en,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic [NBITS-1:0] result,
    output logic             result_valid,
    output logic             ser_data,
    output logic             ser_valid
);

    // One shared down-counter covers sampling, settling and the serial shift.
    localparam int MAX_SS  = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX = (MAX_SS > NBITS) ? MAX_SS : NBITS;
    localparam int CW      = sar_cnt_width(CNT_MAX);
    localparam int KW      = sar_cnt_width(NBITS);

    localparam logic [CW-1:0]    SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [KW-1:0]    MSB_IDX     = KW'(NBITS - 1);
    localparam logic [NBITS-1:0] MSB_CODE    = {1'b1, {(NBITS-1){1'b0}}};

    sar_state_e       state_q,        state_d;
    logic [CW-1:0]    cnt_q,          cnt_d;
    logic [KW-1:0]    bit_q,          bit_d;
    logic [NBITS-1:0] code_q,         code_d;
    logic             sample_en_q,    sample_en_d;
    logic             busy_q,         busy_d;
    logic [NBITS-1:0] result_q,       result_d;
    logic             result_valid_q, result_valid_d;

    logic [NBITS-1:0] bit_mask;
    logic [NBITS-1:0] kept_code;

`ifdef SAR_SERIAL_OUT_EN
    logic tx_busy;
`endif

    // Decision for the bit under trial: keep it when Vin >= Vdac, otherwise clear it.
    assign bit_mask  = NBITS'(1) << bit_q;
    assign kept_code = cmp_in ? code_q : (code_q & ~bit_mask);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_d          = bit_q;
        code_d         = code_q;
        sample_en_d    = sample_en_q;
        busy_d         = busy_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SAMPLE;
                    cnt_d       = SAMPLE_LOAD;
                    sample_en_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            ST_SAMPLE: begin
                if (cnt_q == '0) begin
                    state_d     = ST_TRIAL;
                    cnt_d       = SETTLE_LOAD;
                    bit_d       = MSB_IDX;
                    code_d      = MSB_CODE;
                    sample_en_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            ST_TRIAL: begin
                // cmp_in only matters on the final settle cycle of each bit.
                if (cnt_q == '0) begin
                    if (bit_q == '0) begin
                        state_d        = ST_DONE;
                        result_d       = kept_code;
                        result_valid_d = 1'b1;
                        code_d         = '0;
                    end else begin
                        code_d = kept_code | (bit_mask >> 1);
                        bit_d  = bit_q - KW'(1);
                        cnt_d  = SETTLE_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            ST_DONE: begin
`ifdef SAR_SERIAL_OUT_EN
                state_d = ST_SHIFT;
                cnt_d   = CW'(NBITS - 1);
`else
                state_d = ST_IDLE;
                busy_d  = 1'b0;
`endif
            end

`ifdef SAR_SERIAL_OUT_EN
            ST_SHIFT: begin
                if (cnt_q == '0 || !tx_busy) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif

            default: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                sample_en_d = 1'b0;
                code_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            bit_q          <= '0;
            code_q         <= '0;
            sample_en_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_q          <= bit_d;
            code_q         <= code_d;
            sample_en_q    <= sample_en_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign sample_en    = sample_en_q;
    assign dac_code     = code_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

`ifdef SAR_SERIAL_OUT_EN
    // The serialiser loads during DONE so its first bit lines up with the cycle after result_valid.
    sar_ser_tx #(
        .NBITS (NBITS)
    ) u_ser_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (state_q == ST_DONE),
        .load_data (result_q),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .tx_busy   (tx_busy)
    );
`else
    assign ser_data  = 1'b0;
    assign ser_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - scoreboard bench for sar_adc_ctrl (default and 4-bit/3-settle instances)
module tb_sar_adc_ctrl;

`ifdef SAR_SERIAL_OUT_EN
    localparam bit SER = 1'b1;
`else
    localparam bit SER = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] vin   = 8'h00;
    logic       cmp_in;
    logic       sample_en, busy, result_valid, ser_data, ser_valid;
    logic [7:0] dac_code, result;

    logic       start4 = 1'b0;
    logic [3:0] vin4   = 4'h0;
    logic       cmp4;
    logic       sample_en4, busy4, result_valid4, ser_data4, ser_valid4;
    logic [3:0] dac_code4, result4;

    // Ideal comparator: the analog input sits at code vin.
    assign cmp_in = (vin >= dac_code);
    assign cmp4   = (vin4 >= dac_code4);

    sar_adc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cmp_in       (cmp_in),
        .sample_en    (sample_en),
        .dac_code     (dac_code),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .ser_data     (ser_data),
        .ser_valid    (ser_valid)
    );

    sar_adc_ctrl #(
        .NBITS         (4),
        .SAMPLE_CYCLES (4),
        .SETTLE_CYCLES (3)
    ) dut4 (
        .clk          (clk),
        .rst          (rst),
        .start        (start4),
        .cmp_in       (cmp4),
        .sample_en    (sample_en4),
        .dac_code     (dac_code4),
        .busy         (busy4),
        .result       (result4),
        .result_valid (result_valid4),
        .ser_data     (ser_data4),
        .ser_valid    (ser_valid4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [7:0] exp_v[$];
    int         exp_c[$];

    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (exp_v.size() == 0) begin
                check_eq("spurious_result_valid", 32'd1, 32'd0);
            end else begin
                check_eq("result", result, exp_v.pop_front());
                check_eq("result_valid_cycle", cyc, exp_c.pop_front());
            end
        end
    end

    task automatic convert(input logic [7:0] v, input int extra_n, input int abort_n);
        int         e0;
        int         se_cnt;
        int         k;
        int         last;
        logic [7:0] exp_dac;
        se_cnt = 0;
        last   = SER ? 29 : 21;
        vin    = v;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
        exp_v.push_back(v);
        exp_c.push_back(e0 + 20);
        for (int n = 0; n <= last; n++) begin
            if (n == 0) check_eq("busy_rise", busy, 1);
            if (sample_en) se_cnt++;
            if (n >= 4 && n < 20 && ((n - 4) % 2) == 0) begin
                k       = 7 - (n - 4) / 2;
                exp_dac = ((v >> (k + 1)) << (k + 1)) | (8'd1 << k);
                check_eq($sformatf("dac_k%0d_v%02h", k, v), dac_code, exp_dac);
            end
            if (n == 20) check_eq("dac_done_zero", dac_code, 0);
            if (n >= 21 && n <= 28) begin
                check_eq("ser_valid", ser_valid, SER);
                if (SER) check_eq($sformatf("ser_bit%0d", 28 - n), ser_data, v[28 - n]);
            end
            start = (n == extra_n);
            if (n == abort_n) begin
                rst = 1'b1;
                #1;
                check_eq("abort_outputs", {sample_en, busy, result_valid, ser_valid, ser_data}, 0);
                check_eq("abort_dac", dac_code, 0);
                check_eq("abort_result", result, 0);
                exp_v.delete();
                exp_c.delete();
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (n == last) begin
                check_eq("end_busy", busy, 0);
                check_eq("end_idle", {sample_en, dac_code}, 0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (abort_n < 0) check_eq($sformatf("sample_cycles_v%02h", v), se_cnt, 4);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        bit found;

        repeat (3) @(negedge clk);
        check_eq("reset_hold", {sample_en, busy, result_valid, ser_data, ser_valid, dac_code, result}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_release", {sample_en, busy, result_valid, ser_data, ser_valid, dac_code, result}, 0);

        convert(8'hA5, -1, -1);
        convert(8'h00, -1, -1);
        convert(8'hFF, -1, -1);
        convert(8'hA5, 4, -1);
        convert(8'h5A, SER ? 24 : 20, -1);
        repeat (3) @(negedge clk);
        check_eq("ignored_start_idle", busy, 0);
        convert(8'hC3, -1, 10);
        convert(8'h3C, -1, -1);

        vin4 = 4'h9;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        e0     = cyc;
        found  = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (result_valid4) begin
                found = 1'b1;
                check_eq("p4_result", result4, 4'h9);
                check_eq("p4_cycle", cyc, e0 + 16);
            end else begin
                @(negedge clk);
            end
        end
        if (!found) check_eq("p4_timeout", 0, 1);
        repeat (SER ? 8 : 2) @(negedge clk);
        check_eq("p4_idle", {busy4, sample_en4, ser_valid4, ser_data4, dac_code4}, 0);

        repeat (2) @(negedge clk);
        check_eq("scoreboard_empty", exp_v.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Digital successive-approximation controller for the LPCAS analog macro on the analog pins.
- Drives the track/hold switch (sample_en) and the capacitive-DAC trial code (dac_code) out to the analog front end.
- Reads back the comparator decision (cmp_in) and assembles an NBITS result.
- Optionally streams the result serially for the dedicated output pins.

Parameters:
- NBITS, 8, resolution; DAC code and result width (range 2..12).
- SAMPLE_CYCLES, 4, cycles sample_en is held high (range ≥1).
- SETTLE_CYCLES, 2, cycles per bit trial; the comparator is sampled on the last one (range ≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  single-cycle conversion request.
- cmp_in  in  1  comparator output; 1 means Vin ≥ Vdac. Already synchronised externally.
- sample_en  out  1  track/hold switch enable.
- dac_code  out  NBITS  trial code to the capacitive DAC.
- busy  out  1  conversion or serial shift in progress.
- result  out  NBITS  last completed conversion; held until the next completion.
- result_valid  out  1  one-cycle pulse when result updates.
- ser_data  out  1  serial result bit, MSB first.
- ser_valid  out  1  ser_data qualifier.

Behaviour:
- **Reset:** all outputs are 0, FSM in IDLE, counters cleared. Async assert; deassert is taken synchronously by the first clk edge.
- **FSM states:** IDLE, SAMPLE, TRIAL, DONE.
- **IDLE:**
  - busy=0, sample_en=0, dac_code=0.
  - start=1 at edge E0 → SAMPLE.
- **SAMPLE:**
  - sample_en=1 for exactly SAMPLE_CYCLES cycles.
  - Then bit index k=NBITS-1 → TRIAL, with dac_code = 1<<k.
- **TRIAL:**
  - Hold dac_code for SETTLE_CYCLES cycles.
  - On the last cycle, sample cmp_in:
    - cmp_in=1 → keep bit k.
    - cmp_in=0 → clear bit k.
  - If k>0: set bit k-1, decrement k, stay in TRIAL.
  - If k=0 → DONE.
- **DONE (one cycle):**
  - result ← final code; result_valid=1; dac_code returns to 0.
  - Next state: IDLE (or the serial shift, see below).
- **Timing:**
  - busy goes high in the cycle after E0.
  - result_valid is high in the cycle starting at E0+SAMPLE_CYCLES+NBITS*SETTLE_CYCLES (20 with defaults).
- **start rules:**
  - start while busy=1 is ignored, not queued.
  - start in the same cycle as DONE is ignored.
- **Reset mid-conversion:** aborts immediately. result is cleared to 0 and no result_valid pulse is emitted.
- **Bit arithmetic:** bits are only set or cleared; no adder. The codes 0 and 2^NBITS-1 are both reachable.
- **cmp_in:** sampled only on the final settle cycle; values at other times are ignored.

Optional Feature:
- **Macro:** SAR_SERIAL_OUT_EN.
- **Defined:**
  - After DONE, the FSM enters SHIFT for NBITS cycles; busy stays high.
  - ser_valid=1 and ser_data = result MSB first, one bit per cycle, starting the cycle after result_valid.
  - Then the FSM returns to IDLE.
- **Undefined:**
  - No SHIFT state; DONE goes straight to IDLE.
  - ser_data and ser_valid are tied to 0.

Decomposition:
- **Package sar_pkg:**
  - State enum (IDLE, SAMPLE, TRIAL, DONE, SHIFT).
  - Default NBITS/SAMPLE_CYCLES/SETTLE_CYCLES localparams.
  - Counter-width function (clog2-based).
- **Sub-module sar_ser_tx:**
  - NBITS shift register with load strobe, producing ser_data/ser_valid/tx_busy.
  - Instantiated only under SAR_SERIAL_OUT_EN.

Test Plan:
- **Nominal:** model cmp_in = (0xA5 ≥ dac_code); pulse start → dac_code sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5. result=0xA5 with result_valid one cycle at E0+20; busy=0 afterwards (no macro).
- **Extremes:**
  - Vin code 0x00 → result 0x00.
  - Vin code 0xFF → result 0xFF.
  - sample_en high exactly 4 cycles in each.
- **Start while busy:** second start at E0+5 → ignored; exactly one result_valid pulse; dac_code trajectory unchanged.
- **Reset mid-conversion:** rst at E0+10 → all outputs 0 immediately. Next start converts 0x3C correctly, with no stale bits.
- **Serial (SAR_SERIAL_OUT_EN):**
  - result 0xA5 → ser_valid high 8 cycles, ser_data = 1,0,1,0,0,1,0,1.
  - busy clears after the last bit; a start during the shift is ignored.
- **Parameter sweep:** NBITS=4, SETTLE_CYCLES=3, Vin 0x9 → result 0x9 at E0+4+12.
